sr_flag_bank: RTL and testbench

- Clocked, parametrised successor to the single-bit SR latch: WIDTH independent set/reset flag channels stored in edge-triggered flops, so there is no combinational feedback loop.
- Adds the following, none of which the plain latch has:
  - a defined result when S and R are both asserted (MODE);
  - optional rising-edge input qualification (EDGE);
  - sticky per-channel conflict flags;
  - a synchronous clear;
  - aggregate status outputs.
- Used wherever the design needs latched event/status bits, e.g. interrupt pending flags and error flags.

---
 rtl/sr_flag_bank_pkg.sv | 16 +
 rtl/sr_flag_cell.sv | 70 +++++++
 rtl/sr_flag_bank.sv | 57 +++++
 tb/tb_sr_flag_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_bank_pkg.sv
// Shared definitions for the set/reset flag bank: conflict-resolution
// mode encodings and the width helper for the population count output.
package sr_flag_bank_pkg;

    // Action taken when a channel sees set and reset events in the same cycle
    localparam int SR_MODE_RDOM   = 0;
    localparam int SR_MODE_SDOM   = 1;
    localparam int SR_MODE_TOGGLE = 2;
    localparam int SR_MODE_HOLD   = 3;

    // Bits needed to hold a count of 0..width inclusive
    function automatic int srCountWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One set/reset flag channel: optional rising-edge qualification of the
// request lines, a registered flag bit and a sticky conflict bit.
module sr_flag_cell
    import sr_flag_bank_pkg::*;
#(
    parameter int   MODE      = SR_MODE_RDOM,
    parameter int   EDGE      = 0,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic s_i,
    input  logic r_i,
    output logic q_o,
    output logic conflict_o
);

    logic sHist_q;
    logic rHist_q;
    logic q_q;
    logic q_d;
    logic conflict_q;
    logic conflict_d;
    logic setEvt;
    logic rstEvt;

    // Decode events and resolve the next flag and conflict state
    always_comb begin
        setEvt     = (EDGE != 0) ? (s_i & ~sHist_q) : s_i;
        rstEvt     = (EDGE != 0) ? (r_i & ~rHist_q) : r_i;
        q_d        = q_q;
        conflict_d = conflict_q;
        if (clr_i) begin
            q_d        = RESET_BIT;
            conflict_d = 1'b0;
        end else if (setEvt && rstEvt) begin
            conflict_d = 1'b1;
            case (MODE)
                SR_MODE_RDOM:   q_d = 1'b0;
                SR_MODE_SDOM:   q_d = 1'b1;
                SR_MODE_TOGGLE: q_d = ~q_q;
                default:        q_d = q_q;
            endcase
        end else if (setEvt) begin
            q_d = 1'b1;
        end else if (rstEvt) begin
            q_d = 1'b0;
        end
    end

    // Flag, conflict and request-history registers; history samples every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sHist_q    <= 1'b0;
            rHist_q    <= 1'b0;
            q_q        <= RESET_BIT;
            conflict_q <= 1'b0;
        end else begin
            sHist_q    <= s_i;
            rHist_q    <= r_i;
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    assign q_o        = q_q;
    assign conflict_o = conflict_q;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of WIDTH independent clocked set/reset flags with sticky conflict
// bits, synchronous clear and aggregate any-set / population-count status.
module sr_flag_bank
    import sr_flag_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = SR_MODE_RDOM,
    parameter int               EDGE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic [WIDTH-1:0]                 S,
    input  logic [WIDTH-1:0]                 R,
    output logic [WIDTH-1:0]                 Q,
    output logic [WIDTH-1:0]                 Qn,
    output logic [WIDTH-1:0]                 conflict,
    output logic                             any_set,
    output logic [srCountWidth(WIDTH)-1:0]   count
);

    localparam int CW = srCountWidth(WIDTH);

    logic [WIDTH-1:0] qBits;
    logic [CW-1:0]    onesCount;

    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        sr_flag_cell #(
            .MODE      (MODE),
            .EDGE      (EDGE),
            .RESET_BIT (RESET_VAL[i])
        ) uCell (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (clr),
            .s_i        (S[i]),
            .r_i        (R[i]),
            .q_o        (qBits[i]),
            .conflict_o (conflict[i])
        );
    end

    // Population count of the flag bits, combinational from Q
    always_comb begin
        onesCount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onesCount = onesCount + CW'(qBits[i]);
        end
    end

    assign Q       = qBits;
    assign Qn      = ~qBits;
    assign any_set = |qBits;
    assign count   = onesCount;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed self-checking bench for sr_flag_bank covering every conflict
// mode, edge qualification, clear priority and asynchronous reset.
module tb_sr_flag_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] sLvl = '0;
    logic [3:0] rLvl = '0;
    logic [3:0] sEdge = '0;
    logic [3:0] rEdge = '0;

    logic [3:0] qRst, qnRst, cRst;
    logic       anyRst;
    logic [2:0] cntRst;
    logic [3:0] qM [4];
    logic [3:0] qnM [4];
    logic [3:0] cM [4];
    logic       anyM [4];
    logic [2:0] cntM [4];
    logic [3:0] qE, qnE, cE;
    logic       anyE;
    logic [2:0] cntE;
    logic [0:0] qOne, qnOne, cOne;
    logic       anyOne;
    logic [0:0] cntOne;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    sr_flag_bank #(.WIDTH(4), .MODE(0), .EDGE(0), .RESET_VAL(4'b0101)) uRst (
        .clk(clk), .rst(rst), .clr(clr), .S(sLvl), .R(rLvl),
        .Q(qRst), .Qn(qnRst), .conflict(cRst), .any_set(anyRst), .count(cntRst)
    );

    for (genvar m = 0; m < 4; m++) begin : gMode
        sr_flag_bank #(.WIDTH(4), .MODE(m), .EDGE(0), .RESET_VAL(4'b0000)) uMode (
            .clk(clk), .rst(rst), .clr(clr), .S(sLvl), .R(rLvl),
            .Q(qM[m]), .Qn(qnM[m]), .conflict(cM[m]), .any_set(anyM[m]), .count(cntM[m])
        );
    end

    sr_flag_bank #(.WIDTH(4), .MODE(0), .EDGE(1), .RESET_VAL(4'b0000)) uEdge (
        .clk(clk), .rst(rst), .clr(clr), .S(sEdge), .R(rEdge),
        .Q(qE), .Qn(qnE), .conflict(cE), .any_set(anyE), .count(cntE)
    );

    sr_flag_bank #(.WIDTH(1), .MODE(0), .EDGE(0), .RESET_VAL(1'b0)) uOne (
        .clk(clk), .rst(rst), .clr(clr), .S(sLvl[0:0]), .R(rLvl[0:0]),
        .Q(qOne), .Qn(qnOne), .conflict(cOne), .any_set(anyOne), .count(cntOne)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sL, input logic [3:0] rL,
                                 input logic [3:0] sE, input logic [3:0] rE,
                                 input logic c);
        sLvl  = sL;
        rLvl  = rL;
        sEdge = sE;
        rEdge = rE;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] starting sr_flag_bank bench");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #2;
        checkOutput("rst_q",        qRst,   4'b0101);
        checkOutput("rst_qn",       qnRst,  4'b1010);
        checkOutput("rst_count",    cntRst, 3'd2);
        checkOutput("rst_any",      anyRst, 1'b1);
        checkOutput("rst_conflict", cRst,   4'b0000);
        checkOutput("rst_m0_q",     qM[0],  4'b0000);
        checkOutput("rst_m0_any",   anyM[0], 1'b0);
        checkOutput("rst_one_cnt",  cntOne, 1'b0);

        // Level set and reset
        applyStimulus(4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lvl_set_m0",   qM[0],  4'b0011);
        checkOutput("lvl_set_m2",   qM[2],  4'b0011);
        checkOutput("lvl_set_rst",  qRst,   4'b0111);
        checkOutput("lvl_set_cnt",  cntM[0], 3'd2);
        checkOutput("one_set_cnt",  cntOne, 1'b1);
        checkOutput("one_set_q",    qOne,   1'b1);
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lvl_rst_m0",   qM[0],  4'b0010);
        checkOutput("lvl_rst_cnt",  cntM[0], 3'd1);
        checkOutput("lvl_rst_qn",   qnM[0], 4'b1101);
        checkOutput("one_rst_q",    qOne,   1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lvl_hold_m0",  qM[0],  4'b0010);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("pre_both_m2",  qM[2],  4'b0110);
        checkOutput("pre_both_m3",  qM[3],  4'b0110);

        // Simultaneous set and reset in every mode
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        checkOutput("both_m0_q",    qM[0],  4'b0000);
        checkOutput("both_m1_q",    qM[1],  4'b1111);
        checkOutput("both_m2_q",    qM[2],  4'b1001);
        checkOutput("both_m3_q",    qM[3],  4'b0110);
        checkOutput("both_m1_cnt",  cntM[1], 3'd4);
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("both_m%0d_conf", m), cM[m], 4'b1111);
        end
        checkOutput("both_one_conf", cOne,  1'b1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("sticky_m0",    cM[0],  4'b1111);
        checkOutput("sticky_m3",    cM[3],  4'b1111);
        checkOutput("sticky_m2_q",  qM[2],  4'b1001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        checkOutput("clr_m2_q",     qM[2],  4'b0000);
        checkOutput("clr_m0_conf",  cM[0],  4'b0000);
        checkOutput("clr_rst_q",    qRst,   4'b0101);

        // Clear overrides pending events
        applyStimulus(4'b1111, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        checkOutput("pri_m1_q",     qM[1],  4'b1111);
        checkOutput("pri_m1_conf",  cM[1],  4'b0100);
        checkOutput("pri_rst_q",    qRst,   4'b1011);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        checkOutput("pri_clr_m1_q", qM[1],  4'b0000);
        checkOutput("pri_clr_conf", cM[1],  4'b0000);
        checkOutput("pri_clr_rstq", qRst,   4'b0101);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("pri_lost_m1",  qM[1],  4'b0000);

        // Asynchronous reset between edges
        applyStimulus(4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("async_pre_q",  qM[1],  4'b1010);
        checkOutput("async_pre_rq", qRst,   4'b1111);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_m1_q",   qM[1],  4'b0000);
        checkOutput("async_m1_cnt", cntM[1], 3'd0);
        checkOutput("async_m1_any", anyM[1], 1'b0);
        checkOutput("async_rst_q",  qRst,   4'b0101);
        checkOutput("async_rst_cnt", cntRst, 3'd2);
        sLvl  = 4'b0000;
        sEdge = 4'b0010;
        #1 rst = 1'b0;

        // Edge mode: a line high at the first edge after reset is one event
        applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0);
        checkOutput("edge_first",   qE,     4'b0010);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        checkOutput("edge_clr",     qE,     4'b0000);

        // Edge mode: held set, reset pulse, re-raise
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        checkOutput("edge_set",     qE,     4'b0001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        end
        checkOutput("edge_held",    qE,     4'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);
        checkOutput("edge_rpulse",  qE,     4'b0000);
        checkOutput("edge_noconf",  cE,     4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        checkOutput("edge_stay0",   qE,     4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("edge_drop",    qE,     4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        checkOutput("edge_reraise", qE,     4'b0001);
        checkOutput("edge_any",     anyE,   1'b1);
        checkOutput("edge_cnt",     cntE,   3'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
